// File: rtl/mantle_concat_stream.sv
// Frame concatenator: drains N ready/valid packet streams in channel order
// (0..N-1) into a single registered output stream, one packet per channel per frame.
module mantle_concat_stream #(
  parameter  int WIDTH = 32,
  parameter  int N     = 3,
  parameter  int CNT_W = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_chan,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               frame_done
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  logic             vld_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             done_q;

  logic             load_en;
  logic             accept;
  logic             xfer;
  logic             sel_last;
  logic             at_end;
  logic [WIDTH-1:0] sel_word;

  // The output register may take a new word whenever it is empty or being drained.
  assign load_en  = !vld_q || out_ready;
  assign accept   = !reset && load_en && in_valid[sel_q];
  assign xfer     = vld_q && out_ready;
  assign sel_last = in_last[sel_q];
  assign at_end   = (sel_q == SEL_W'(N - 1));
  assign sel_word = in_data[sel_q*WIDTH +: WIDTH];
  assign cnt_inc  = sat_inc(cnt_q);

  // Channel selector: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Channel selector: next state
  always_comb begin
    sel_d = sel_q;
    if (accept && sel_last) begin
      sel_d = at_end ? '0 : sel_q + 1'b1;
    end
  end

  // Channel selector: outputs
  always_comb begin
    in_ready = '0;
    if (!reset && load_en) begin
      in_ready[sel_q] = 1'b1;
    end
  end

  // Output register stage: a same-cycle accept overwrites the departing word
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      last_q <= sel_last && at_end;
      data_q <= sel_word;
      chan_q <= sel_q;
    end else if (xfer) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = last_q ? '0 : cnt_inc;
    end
  end

  // Frame bookkeeping stage
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= xfer && last_q;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = vld_q;
  assign out_last   = last_q;
  assign out_chan   = chan_q;
  // The visible count already includes a word that is transferring this cycle.
  assign word_cnt   = reset ? '0 : (xfer ? cnt_inc : cnt_q);
  assign frame_done = done_q && !reset;

endmodule

// File: tb/tb_mantle_concat_stream.sv
// Directed bench for mantle_concat_stream: per-channel producers, a scoreboard of
// expected output words in frame order, and a second instance with a 4-bit counter.
module tb_mantle_concat_stream;
  localparam int WIDTH = 32;
  localparam int N     = 3;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid, in_last;
  logic [N-1:0]       in_ready, in_ready_s;
  logic [WIDTH-1:0]   out_data, out_data_s;
  logic               out_valid, out_valid_s, out_last, out_last_s;
  logic               out_ready;
  logic [CW-1:0]      out_chan, out_chan_s;
  logic [7:0]         word_cnt;
  logic [3:0]         word_cnt_s;
  logic               frame_done, frame_done_s;

  mantle_concat_stream #(.WIDTH(WIDTH), .N(N), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .out_chan(out_chan), .word_cnt(word_cnt), .frame_done(frame_done)
  );

  mantle_concat_stream #(.WIDTH(WIDTH), .N(N), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s), .out_last(out_last_s),
    .out_ready(out_ready), .out_chan(out_chan_s), .word_cnt(word_cnt_s), .frame_done(frame_done_s)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               chan;
    logic             last;
  } exp_t;

  exp_t sb[$];

  logic [WIDTH-1:0] pdata [N][DEPTH];
  logic             plast [N][DEPTH];
  int pcnt [N];
  int pidx [N];
  int pstart [N];
  int n_acc [N];

  int n_assert = 0;
  int n_fail   = 0;
  int exp_sel  = 0;
  int cnt8     = 0;
  int cnt4     = 0;
  logic fd_exp = 1'b0;
  logic stall_hold = 1'b0;
  logic [WIDTH-1:0] held_d;
  logic [CW-1:0]    held_c;
  logic             held_l;
  int cyc = 0;
  int first_x, last_x, n_x;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prod();
    for (int c = 0; c < N; c++) begin
      pcnt[c] = 0; pidx[c] = 0; pstart[c] = 0; n_acc[c] = 0;
    end
  endtask

  // Queue one packet on channel ch and record its words as expected output.
  task automatic add_packet(input int ch, input int n, input logic [WIDTH-1:0] base);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      pdata[ch][pcnt[ch]] = base + WIDTH'(k);
      plast[ch][pcnt[ch]] = (k == n - 1);
      pcnt[ch]++;
      e.data = base + WIDTH'(k);
      e.chan = ch;
      e.last = (ch == N - 1) && (k == n - 1);
      sb.push_back(e);
    end
  endtask

  function automatic logic rdy_of(input int mode, input int c);
    if (mode == 0) return 1'b1;
    case (c % 4)
      0, 3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input logic rdy);
    logic xfer, nl, load_en, fd_next, lastv;
    int acc, n8, n4;
    exp_t e;
    for (int c = 0; c < N; c++) begin
      in_valid[c] = (pidx[c] < pcnt[c]) && (cyc >= pstart[c]);
      in_data[c*WIDTH +: WIDTH] = in_valid[c] ? pdata[c][pidx[c]] : 32'hDEAD_0000 + WIDTH'(c);
      in_last[c] = in_valid[c] ? plast[c][pidx[c]] : 1'b1;
    end
    out_ready = rdy;
    #1;
    load_en = !out_valid || out_ready;
    chk(in_ready,   load_en ? (64'd1 << exp_sel) : 64'd0, "in_ready");
    chk(in_ready_s, load_en ? (64'd1 << exp_sel) : 64'd0, "in_ready_s");
    if (stall_hold) begin
      chk(out_valid, 1'b1, "stall_valid");
      chk(out_data, held_d, "stall_data");
      chk(out_chan, held_c, "stall_chan");
      chk(out_last, held_l, "stall_last");
    end
    chk(frame_done,   fd_exp, "frame_done");
    chk(frame_done_s, fd_exp, "frame_done_s");
    xfer = out_valid && out_ready;
    nl = 1'b0; n8 = cnt8; n4 = cnt4;
    fd_next = 1'b0;
    if (xfer) begin
      if (sb.size() == 0) begin
        chk(out_valid, 1'b0, "extra_word");
      end else begin
        e = sb.pop_front();
        n8 = (cnt8 < 255) ? cnt8 + 1 : 255;
        n4 = (cnt4 < 15) ? cnt4 + 1 : 15;
        chk(out_data, e.data, "out_data");
        chk(out_chan, e.chan, "out_chan");
        chk(out_last, e.last, "out_last");
        chk(word_cnt, n8, "word_cnt");
        chk(out_valid_s, 1'b1, "out_valid_s");
        chk(out_data_s, e.data, "out_data_s");
        chk(out_chan_s, e.chan, "out_chan_s");
        chk(out_last_s, e.last, "out_last_s");
        chk(word_cnt_s, n4, "word_cnt_sat");
        nl = e.last;
        fd_next = e.last;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        n_x++;
      end
    end
    acc = -1;
    for (int c = 0; c < N; c++) if (in_valid[c] && in_ready[c]) acc = c;
    lastv = (acc >= 0) ? in_last[acc] : 1'b0;
    stall_hold = out_valid && !out_ready;
    held_d = out_data; held_c = out_chan; held_l = out_last;
    @(posedge clk);
    if (acc >= 0) begin
      pidx[acc]++;
      n_acc[acc]++;
      if (acc == exp_sel && lastv) exp_sel = (exp_sel + 1) % N;
    end
    if (xfer) begin
      cnt8 = nl ? 0 : n8;
      cnt4 = nl ? 0 : n4;
    end
    fd_exp = fd_next;
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_step();
    reset = 1'b1;
    in_valid = '1; in_last = '1; in_data = {N{32'hA5A5_5A5A}};
    out_ready = 1'b1;
    #1;
    chk(in_ready, 0, "rst_in_ready");
    chk(word_cnt, 0, "rst_word_cnt");
    chk(word_cnt_s, 0, "rst_word_cnt_s");
    chk(frame_done, 0, "rst_frame_done");
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    clear_prod();
    exp_sel = 0; cnt8 = 0; cnt4 = 0; fd_exp = 1'b0; stall_hold = 1'b0;
    @(negedge clk);
    chk(out_valid, 0, "post_rst_valid");
    chk(out_last, 0, "post_rst_last");
    chk(out_data, 0, "post_rst_data");
    chk(out_chan, 0, "post_rst_chan");
    chk(word_cnt, 0, "post_rst_word_cnt");
    chk(frame_done, 0, "post_rst_frame_done");
    chk(in_ready, 3'b001, "post_rst_sel0");
    in_valid = '0;
  endtask

  task automatic run(input int mode, input int budget, input bit bubble_chk);
    cyc = 0; first_x = -1; last_x = -1; n_x = 0;
    while (sb.size() > 0 && cyc < budget) step(rdy_of(mode, cyc));
    chk(sb.size(), 0, "words_pending");
    if (bubble_chk) chk(last_x - first_x + 1, n_x, "bubbles");
    step(1'b1);
    step(1'b1);
    chk(out_valid, 0, "idle_valid");
    chk(word_cnt, 0, "idle_word_cnt");
    chk(word_cnt_s, 0, "idle_word_cnt_s");
  endtask

  initial begin
    reset = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    first_x = -1; last_x = -1; n_x = 0;
    held_d = '0; held_c = '0; held_l = 1'b0;
    clear_prod();
    @(negedge clk);
    reset_step();

    // Reference lengths 9/6/7, full throughput
    add_packet(0, 9, 32'h000);
    add_packet(1, 6, 32'h100);
    add_packet(2, 7, 32'h200);
    run(0, 200, 1'b1);

    // Back-to-back frames 1/1/1 then 2/3/4
    clear_prod();
    add_packet(0, 1, 32'h1000); add_packet(1, 1, 32'h1100); add_packet(2, 1, 32'h1200);
    add_packet(0, 2, 32'h2000); add_packet(1, 3, 32'h2100); add_packet(2, 4, 32'h2200);
    run(0, 200, 1'b1);

    // Backpressure 1,0,0,1 with the reference lengths
    clear_prod();
    add_packet(0, 9, 32'h3000);
    add_packet(1, 6, 32'h3100);
    add_packet(2, 7, 32'h3200);
    run(1, 300, 1'b0);

    // Out-of-order producers: ch2 early, ch0 late
    clear_prod();
    add_packet(0, 2, 32'h4000);
    add_packet(1, 1, 32'h4100);
    add_packet(2, 4, 32'h4200);
    pstart[0] = 10;
    run(0, 200, 1'b1);

    // Reset mid-frame after ch1's third accept
    clear_prod();
    add_packet(0, 4, 32'h5000);
    add_packet(1, 6, 32'h5100);
    add_packet(2, 2, 32'h5200);
    cyc = 0; first_x = -1; last_x = -1; n_x = 0;
    while (n_acc[1] < 3 && cyc < 100) step(1'b1);
    chk(n_acc[1], 3, "ch1_accepts_before_reset");
    reset_step();
    add_packet(0, 2, 32'h6000);
    add_packet(1, 2, 32'h6100);
    add_packet(2, 2, 32'h6200);
    run(0, 200, 1'b1);

    // Counter saturation: 20/1/1 words against the 4-bit counter
    clear_prod();
    add_packet(0, 20, 32'h7000);
    add_packet(1, 1, 32'h7100);
    add_packet(2, 1, 32'h7200);
    run(0, 200, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mantle_concat_stream.md
Name: mantle_concat_stream

Overview:
- Streaming, sequential successor to the combinational N-array concatenator.
- Accepts N independent ready/valid word streams, one packet per channel per frame.
- Emits one output stream per frame: channel 0's packet, then channel 1's, through channel N-1's.
- Packet lengths are set at runtime by each channel's `in_last`, not by elaboration-time array sizes.
- Sits between per-lane producers (e.g. tile row buffers) and a single downstream consumer; the output is registered for timing closure.

Parameters:
- WIDTH, 32: data word width in bits.
- N, 3: number of input channels; legal range 2..16.
- CNT_W, 8: width of the frame word counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  flattened channel words; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel word valid.
- in_last  input  N  per-channel end-of-packet, qualified by in_valid.
- in_ready  output  N  per-channel ready; at most one bit set in any cycle.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  output word valid.
- out_last  output  1  final word of the frame (last word of channel N-1).
- out_ready  input  1  downstream ready.
- out_chan  output  max(1,$clog2(N))  source channel of the current out_data.
- word_cnt  output  CNT_W  words transferred downstream in the current frame, including the current transfer's word once it completes.
- frame_done  output  1  one-cycle pulse in the cycle after the out_last word transfers.

Behaviour:
- Reset (synchronous, active-high, dominates all other events):
  - out_valid=0, out_last=0, out_data=0, out_chan=0.
  - sel=0, word_cnt=0, frame_done=0, in_ready=0 during the reset cycle.
  - Reset mid-frame discards the partial frame and any held output word; the next frame starts at channel 0.
- State: channel selector `sel` (0..N-1), acting as an N-state FSM; CH_i means "draining channel i".
- Output register:
  - load_en = !out_valid || out_ready.
  - in_ready[sel] = load_en; all other in_ready bits are 0.
  - Input accept: in_valid[sel] && in_ready[sel].
- On accept:
  - out_data <= channel sel word; out_chan <= sel; out_valid <= 1.
  - out_last <= in_last[sel] && (sel==N-1).
- When out_valid && out_ready and no accept occurs that cycle: out_valid <= 0.
- Latency and throughput:
  - One cycle from input accept to out_valid.
  - Full throughput of 1 word/cycle while out_ready is held high.
  - No combinational path from out_ready to out_data.
- Transitions on an accept with in_last[sel]=1:
  - sel < N-1: sel <= sel+1.
  - sel == N-1: sel <= 0 (wrap).
- Accept with in_last[sel]=0: sel holds.
- Every packet is at least one word; a word carrying in_last is that packet's final word.
- Non-selected channels:
  - They are held off (ready=0) and may present valid indefinitely without effect.
  - A non-selected channel's valid or last is ignored.
- Downstream transfer is out_valid && out_ready:
  - word_cnt increments on each transfer and saturates at 2^CNT_W-1; it does not wrap.
  - A transfer with out_last=1 sets word_cnt <= 0 and frame_done <= 1 for the next cycle only.
- Simultaneous events:
  - A downstream transfer and an input accept in the same cycle: the new word replaces the old one, out_valid stays 1, and word_cnt counts the transfer.
  - Channel N-1's last word and channel 0's first word are never in the register together; the frame boundary costs no bubble.
- Stall: with out_ready=0, out_data, out_last and out_chan are held stable while out_valid=1 (AXI-style).

Test Plan:
- Reference lengths. N=3, WIDTH=32; ch0 sends 9 words 0x000..0x008, ch1 6 words 0x100..0x105, ch2 7 words 0x200..0x206; out_ready=1.
  - Required: 22 words in order 0x000..0x008, 0x100..0x105, 0x200..0x206.
  - out_chan 0→1→2 at word indices 9 and 15.
  - out_last only on 0x206; frame_done pulses once the cycle after.
  - 22 consecutive out_valid cycles, no bubbles.
- Back-to-back frames. Two frames of lengths 1,1,1 then 2,3,4.
  - Required: out_last on the 3rd and 12th outputs.
  - word_cnt reads 3 and 9 on the respective out_last transfer cycles, then 0.
  - Zero idle cycles between the frames.
- Backpressure. Frame of 9/6/7 words with out_ready toggling 1,0,0,1 repeating.
  - Required: out_data stable on every out_ready=0 cycle.
  - No word dropped or duplicated; in_ready[sel]=0 whenever out_valid && !out_ready.
- Out-of-order producers. ch2 asserts valid with 4 words from cycle 0; ch0 starts at cycle 10 with 2 words; ch1 supplies 1 word.
  - Required: in_ready[2]=0 until ch1's last is accepted.
  - Output order is ch0, ch1, ch2.
- Reset mid-frame. Assert reset on the cycle after ch1's 3rd accept.
  - Required: next cycle shows out_valid=0, word_cnt=0, sel=0.
  - The following frame 2/2/2 outputs correctly, beginning with ch0.
- Counter saturation. CNT_W=4; ch0 packet of 20 words, ch1 and ch2 1 word each.
  - Required: word_cnt stops at 15, holds through the remaining transfers including the out_last word, then returns to 0.
